// File: rtl/dual_port_pkg.sv
// Shared types for the dual-port RAM request controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: port FSM state enum, packed request latch struct, latency helper.
package dual_port_pkg;

    localparam int DP_DATA_WIDTH = 8;
    localparam int DP_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } port_state_t;

    typedef struct packed {
        logic                     we;
        logic [DP_ADDR_WIDTH-1:0] addr;
        logic [DP_DATA_WIDTH-1:0] wdata;
    } req_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dpram_port_ctrl_if.sv
// One RAM port's bundle: request channel, response pulse and RAM-side signals.
// Latency: n/a (wiring only).
// Backpressure: req_ready from the controller; requester holds req_* while valid & !ready.
// Modports: slave = controller view, master = requester/RAM view.
interface dpram_port_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dpram_port_seq.sv
// Single-port sequencer: latches a request, holds it on the RAM for LAT cycles, emits a response pulse.
// Latency: accept at edge T -> ram_en T+1..T+LAT, resp_valid at T+LAT+1, idle again at T+LAT+2.
// Backpressure: accepts only when the parent asserts accept (valid & ready decoded upstream).
// Ports: clk/rst_n, accept + request fields in, RAM read data in; state, response and RAM drive out.
module dpram_port_seq
    import dual_port_pkg::*;
#(
    parameter int DATA_WIDTH    = DP_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DP_ADDR_WIDTH,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  accept,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output port_state_t           state,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata
);
    localparam int MAX_LAT = max_int(READ_LATENCY, WRITE_LATENCY);
    // Keep at least one bit so LAT = 1 still has a legal counter.
    localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

    req_t          cur;
    logic [CW-1:0] cnt;

    // RAM-side address/data come straight off the request latch so they cannot move mid-access.
    assign ram_we    = cur.we;
    assign ram_addr  = cur.addr;
    assign ram_wdata = cur.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur        <= '0;
            cnt        <= '0;
            ram_en     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur    <= '{we: req_we, addr: req_addr, wdata: req_wdata};
                        cnt    <= req_we ? WR_LOAD : RD_LOAD;
                        ram_en <= 1'b1;
                        state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Last access cycle: RAM read data is valid now.
                        ram_en     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= cur.we ? '0 : ram_rdata;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/dpram_port_ctrl.sv
// Two-port RAM request controller: per-port sequencers plus address-collision arbitration.
// Latency: LAT+1 cycles accept-to-response per port; one op per LAT+2 cycles per port.
// Backpressure: req_ready low while busy, while the other port holds a conflicting access,
//               or when losing a same-cycle write conflict (round-robin via prio).
// Ports: clk, rst_n, port_a / port_b (dpram_port_ctrl_if.slave).
module dpram_port_ctrl
    import dual_port_pkg::*;
#(
    parameter int DATA_WIDTH    = DP_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DP_ADDR_WIDTH,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    dpram_port_ctrl_if.slave  port_a,
    dpram_port_ctrl_if.slave  port_b
);
    port_state_t state_a, state_b;
    logic        hazard_a, hazard_b, conflict, prio;
    logic        ready_a, ready_b;

    // A busy port blocks an equal-address request on the other side if either op writes.
    assign hazard_a = (state_b != IDLE) && (port_b.ram_addr == port_a.req_addr)
                      && (port_b.ram_we || port_a.req_we);
    assign hazard_b = (state_a != IDLE) && (port_a.ram_addr == port_b.req_addr)
                      && (port_a.ram_we || port_b.req_we);

    assign conflict = (state_a == IDLE) && (state_b == IDLE)
                      && port_a.req_valid && port_b.req_valid
                      && (port_a.req_addr == port_b.req_addr)
                      && (port_a.req_we || port_b.req_we);

    assign ready_a = (state_a == IDLE) && !hazard_a && !(conflict && prio);
    assign ready_b = (state_b == IDLE) && !hazard_b && !(conflict && !prio);

    assign port_a.req_ready = ready_a;
    assign port_b.req_ready = ready_b;

    // The granted port is always idle and valid, so every conflict consumes one grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (conflict) begin
            prio <= ~prio;
        end
    end

    dpram_port_seq #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .READ_LATENCY(READ_LATENCY), .WRITE_LATENCY(WRITE_LATENCY)
    ) u_seq_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (port_a.req_valid && ready_a),
        .req_we     (port_a.req_we),
        .req_addr   (port_a.req_addr),
        .req_wdata  (port_a.req_wdata),
        .ram_rdata  (port_a.ram_rdata),
        .state      (state_a),
        .resp_valid (port_a.resp_valid),
        .resp_rdata (port_a.resp_rdata),
        .ram_en     (port_a.ram_en),
        .ram_we     (port_a.ram_we),
        .ram_addr   (port_a.ram_addr),
        .ram_wdata  (port_a.ram_wdata)
    );

    dpram_port_seq #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .READ_LATENCY(READ_LATENCY), .WRITE_LATENCY(WRITE_LATENCY)
    ) u_seq_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .accept     (port_b.req_valid && ready_b),
        .req_we     (port_b.req_we),
        .req_addr   (port_b.req_addr),
        .req_wdata  (port_b.req_wdata),
        .ram_rdata  (port_b.ram_rdata),
        .state      (state_b),
        .resp_valid (port_b.resp_valid),
        .resp_rdata (port_b.resp_rdata),
        .ram_en     (port_b.ram_en),
        .ram_we     (port_b.ram_we),
        .ram_addr   (port_b.ram_addr),
        .ram_wdata  (port_b.ram_wdata)
    );
endmodule

// File: tb/tb_dpram_port_ctrl.sv
// Self-checking bench for dpram_port_ctrl with a behavioural two-port RAM and a response scoreboard.
// Latency: n/a.
// Backpressure: requester tasks hold requests until ready.
module tb_dpram_port_ctrl;
    localparam int LAT = 3;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem   [8];
    logic [7:0] model [8];
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    dpram_port_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ia ();
    dpram_port_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ib ();

    dpram_port_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(LAT), .WRITE_LATENCY(LAT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .port_a (ia),
        .port_b (ib)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int i);
        return 8'h5A ^ 8'(i * 17);
    endfunction

    // Behavioural RAM: contents loaded during the first reset, registered reads.
    always @(posedge clk) begin
        if (cyc < 4) begin
            for (int i = 0; i < 8; i++) mem[i] <= init_val(i);
        end else begin
            if (ia.ram_en && ia.ram_we) mem[ia.ram_addr] <= ia.ram_wdata;
            if (ib.ram_en && ib.ram_we) mem[ib.ram_addr] <= ib.ram_wdata;
        end
        if (ia.ram_en && !ia.ram_we) ia.ram_rdata <= mem[ia.ram_addr];
        if (ib.ram_en && !ib.ram_we) ib.ram_rdata <= mem[ib.ram_addr];
    end

    // Response scoreboard: every response must match the oldest expectation for that port.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ia.resp_valid) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL resp_a_unexpected got rdata=%02h want no response", ia.resp_rdata);
                end else begin
                    ea = qa.pop_front();
                    if (ia.resp_rdata !== ea.data || cyc != ea.cyc) begin
                        errors++;
                        $display("FAIL resp_a got rdata=%02h cyc=%0d want rdata=%02h cyc=%0d",
                                 ia.resp_rdata, cyc, ea.data, ea.cyc);
                    end
                end
            end
            if (ib.resp_valid) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_b_unexpected got rdata=%02h want no response", ib.resp_rdata);
                end else begin
                    eb = qb.pop_front();
                    if (ib.resp_rdata !== eb.data || cyc != eb.cyc) begin
                        errors++;
                        $display("FAIL resp_b got rdata=%02h cyc=%0d want rdata=%02h cyc=%0d",
                                 ib.resp_rdata, cyc, eb.data, eb.cyc);
                    end
                end
            end
        end
    end

    // Drive one request, wait (bounded) for acceptance, record the expected response.
    task automatic do_req(input bit p, input bit we, input logic [2:0] addr,
                          input logic [7:0] wdata, output int acc);
        logic rdy;
        bit   done;
        exp_t e;
        acc  = -1;
        done = 0;
        if (!p) begin
            ia.req_valid = 1'b1; ia.req_we = we; ia.req_addr = addr; ia.req_wdata = wdata;
        end else begin
            ib.req_valid = 1'b1; ib.req_we = we; ib.req_addr = addr; ib.req_wdata = wdata;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            rdy = p ? ib.req_ready : ia.req_ready;
            if (rdy) begin
                acc   = cyc + 1;
                e.cyc = acc + LAT;
                if (we) begin
                    model[addr] = wdata;
                    e.data      = 8'h00;
                end else begin
                    e.data = model[addr];
                end
                if (p) qb.push_back(e);
                else   qa.push_back(e);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        if (!p) ia.req_valid = 1'b0;
        else    ib.req_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout port=%0d got no ready want ready within 60 cycles", p);
        end
    endtask

    task automatic drain();
        bit empty;
        empty = 0;
        for (int i = 0; i < 30 && !empty; i++) begin
            @(negedge clk);
            empty = (qa.size() == 0) && (qb.size() == 0);
        end
        checks++;
        if (!empty) begin
            errors++;
            $display("FAIL drain got pending a=%0d b=%0d want 0 0", qa.size(), qb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] got_a, got_b;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got_a = {ia.ram_en, ia.ram_we, ia.ram_addr, ia.ram_wdata, ia.resp_valid, ia.req_ready};
            got_b = {ib.ram_en, ib.ram_we, ib.ram_addr, ib.ram_wdata, ib.resp_valid, ib.req_ready};
            checks++;
            if (got_a !== 22'h1 || ia.resp_rdata !== 8'h00) begin
                errors++;
                $display("FAIL reset_a got %06h/%02h want 000001/00", got_a, ia.resp_rdata);
            end
            checks++;
            if (got_b !== 22'h1 || ib.resp_rdata !== 8'h00) begin
                errors++;
                $display("FAIL reset_b got %06h/%02h want 000001/00", got_b, ib.resp_rdata);
            end
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_read();
        int acc;
        int en_cnt;
        en_cnt = 0;
        do_req(0, 0, 3'd3, 8'h00, acc);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (ia.ram_en) begin
                en_cnt++;
                checks++;
                if (ia.ram_addr !== 3'd3 || ia.ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL read_ram_addr got addr=%0d we=%0b want addr=3 we=0", ia.ram_addr, ia.ram_we);
                end
            end
            checks++;
            if (ia.req_ready !== (k == 5)) begin
                errors++;
                $display("FAIL read_ready k=%0d got %0b want %0b", k, ia.req_ready, (k == 5));
            end
        end
        checks++;
        if (en_cnt != LAT) begin
            errors++;
            $display("FAIL read_en_cycles got %0d want %0d", en_cnt, LAT);
        end
        drain();
    endtask

    task automatic test_write_read();
        int acc1, acc2;
        do_req(0, 1, 3'd5, 8'hA5, acc1);
        do_req(0, 0, 3'd5, 8'h00, acc2);
        checks++;
        if (acc2 < acc1 + LAT + 2) begin
            errors++;
            $display("FAIL back_to_back_spacing got %0d want >= %0d", acc2 - acc1, LAT + 2);
        end
        drain();
    endtask

    task automatic test_conflict(input logic [7:0] da, input logic [7:0] db, input bit a_first);
        int acc_a, acc_b, acc_r;
        fork
            do_req(0, 1, 3'd2, da, acc_a);
            do_req(1, 1, 3'd2, db, acc_b);
        join
        checks++;
        if (a_first ? (acc_b < acc_a + LAT + 2) : (acc_a < acc_b + LAT + 2)) begin
            errors++;
            $display("FAIL conflict_order got acc_a=%0d acc_b=%0d want %s first by >= %0d",
                     acc_a, acc_b, a_first ? "A" : "B", LAT + 2);
        end
        drain();
        do_req(0, 0, 3'd2, 8'h00, acc_r);
        drain();
    endtask

    task automatic test_parallel_reads();
        int acc_a, acc_b;
        fork
            do_req(0, 0, 3'd7, 8'h00, acc_a);
            do_req(1, 0, 3'd7, 8'h00, acc_b);
        join
        checks++;
        if (acc_a != acc_b) begin
            errors++;
            $display("FAIL parallel_reads got acc_a=%0d acc_b=%0d want equal", acc_a, acc_b);
        end
        drain();
    endtask

    task automatic test_hazard();
        int acc_a, acc_b;
        acc_a = -1;
        fork
            do_req(0, 1, 3'd4, 8'h3C, acc_a);
            begin
                @(posedge clk);
                #1;
                do_req(1, 0, 3'd4, 8'h00, acc_b);
            end
        join
        checks++;
        if (acc_b < acc_a + LAT + 2) begin
            errors++;
            $display("FAIL hazard_stall got acc_b-acc_a=%0d want >= %0d", acc_b - acc_a, LAT + 2);
        end
        drain();
    endtask

    task automatic test_reset_mid_access();
        int acc;
        do_req(0, 0, 3'd1, 8'h00, acc);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ia.ram_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_en got %0b want 0", ia.ram_en);
        end
        qa.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (ia.resp_valid !== 1'b0 || ia.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_after got resp_valid=%0b ready=%0b want 0 1",
                         ia.resp_valid, ia.req_ready);
            end
        end
    endtask

    initial begin
        ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_addr = '0; ia.req_wdata = '0;
        ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_addr = '0; ib.req_wdata = '0;
        for (int i = 0; i < 8; i++) model[i] = init_val(i);
        test_reset();
        test_read();
        test_write_read();
        test_conflict(8'h11, 8'h22, 1'b1);
        test_conflict(8'h33, 8'h44, 1'b0);
        test_parallel_reads();
        test_hazard();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dpram_port_ctrl.md
# dpram_port_ctrl

Request-level controller for the two-port synchronous RAM. Each RAM port is fronted by a valid/ready request channel. The controller holds each port's RAM signals stable for the RAM's fixed access latency and returns read data and write acknowledges as a one-cycle response. It also arbitrates address collisions between the two ports. It sits between the two bus-side requesters and the RAM instance.

## Interface

**Parameters**
- DATA_WIDTH, 8, data bits per word
- ADDR_WIDTH, 3, address bits (depth 2**ADDR_WIDTH)
- READ_LATENCY, 3, cycles the RAM needs an asserted read before ram_x_rdata is valid; ≥1
- WRITE_LATENCY, 3, cycles a write must be held on the RAM port; ≥1

**Ports** (x ∈ {a, b}, one identical set per port)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_x_valid  in  1  request present
- req_x_ready  out  1  controller accepts a request this cycle
- req_x_we  in  1  1 = write, 0 = read
- req_x_addr  in  ADDR_WIDTH  word address
- req_x_wdata  in  DATA_WIDTH  write data
- resp_x_valid  out  1  one-cycle completion pulse (read data or write ack)
- resp_x_rdata  out  DATA_WIDTH  read data; 0 for write acks
- ram_x_en  out  1  RAM port enable
- ram_x_we  out  1  RAM port write enable
- ram_x_addr  out  ADDR_WIDTH  RAM port address
- ram_x_wdata  out  DATA_WIDTH  RAM port write data
- ram_x_rdata  in  DATA_WIDTH  RAM port read data

## Operation

**Per-port FSM:** IDLE → ACCESS → DONE → IDLE.
- **IDLE:** req_x_ready = 1 unless blocked by the collision rules below.
  - On accept (valid & ready), latch we/addr/wdata.
  - Load the counter with LAT−1, where LAT = READ_LATENCY or WRITE_LATENCY.
- **ACCESS:**
  - ram_x_en = 1; ram_x_we, ram_x_addr and ram_x_wdata are driven from the latched values and held constant.
  - The counter decrements each cycle. At 0, go to DONE.
  - On a read, capture ram_x_rdata on that same cycle.
- **DONE:**
  - resp_x_valid = 1 for exactly one cycle.
  - resp_x_rdata = captured data on a read, 0 on a write.
  - ram_x_en = 0. Next state is IDLE.

**Collision rules.** These are evaluated in IDLE against the same-cycle request on the other port.
- **Hazard stall:** if the other port is in ACCESS or DONE on an equal address and either op is a write, this port's ready = 0 until the other port returns to IDLE.
- **Simultaneous conflict:** both ports are IDLE and valid, addresses are equal, and at least one op is a write.
  - Only the port named by the priority bit `prio` (0 = A, 1 = B) gets ready.
  - `prio` toggles after each such conflict.
- Two reads to the same address never conflict.
- Different addresses never conflict.

**Reset:**
- All FSMs go to IDLE and counters to 0.
- `prio` = 0 (A first).
- Reset mid-operation drops the in-flight access with no response.

## Timing

- Accept at edge T:
  - ram_x_en is high for cycles T+1 … T+LAT.
  - resp_x_valid is high in cycle T+LAT+1.
  - req_x_ready returns high at T+LAT+2.
- Throughput is one op per LAT+2 cycles per port.
- Reset values:
  - ram_x_en, ram_x_we, ram_x_addr, ram_x_wdata, resp_x_valid, resp_x_rdata are all 0.
  - req_x_ready = 1 (IDLE).
- All outputs are registered except req_x_ready, which decodes from state plus the collision terms.
- Counter width is $clog2(max(READ_LATENCY, WRITE_LATENCY)). LAT = 1 means ACCESS lasts one cycle.
- The requester must hold req_x_* stable while valid & !ready.

## Structure

- **dual_port_pkg** holds the port FSM state enum (IDLE, ACCESS, DONE) and a packed request struct {we, addr, wdata} sized by the package parameters.
- **dpram_port_seq** is the sub-module: one FSM, counter, request latch and read capture. It is instantiated twice.
- **Top level** holds only the collision logic and the `prio` register.

## Test plan

- **Reset/read:** after reset, port A reads addr 3.
  - ram_a_en is high 3 cycles with addr 3.
  - resp_a_valid pulses at T+4 with the RAM data.
  - All outputs are 0 during reset.
- **Write then read:** A writes 0xA5 to addr 5, then A reads addr 5.
  - The write ack has rdata = 0.
  - The read returns 0xA5.
  - The second accept is no earlier than T+5.
- **Simultaneous write conflict:** A and B both write addr 2 in the same cycle (A 0x11, B 0x22).
  - A is granted first and B stalls until A reaches IDLE.
  - Final read of addr 2 = 0x22.
  - Repeating the same conflict grants B first.
- **Parallel reads:** A and B both read addr 7 in the same cycle. Both are accepted that cycle and both responses arrive at T+4.
- **Hazard stall:** B requests a read of addr 4 while A is in ACCESS writing 0x3C to addr 4.
  - req_b_ready stays low until A is in IDLE.
  - B's read returns 0x3C.
- **Reset mid-access:** assert rst_n low during A's second ACCESS cycle.
  - ram_a_en drops immediately.
  - No resp_a_valid is produced.
  - req_a_ready = 1 after reset.
